// File: rtl/uart_sync_fifo_128x8_pkg.sv
// Shared sizing constants for the UART byte FIFO and its backing RAM.
package uart_sync_fifo_128x8_pkg;

  localparam int FIFO_DEPTH    = 128;
  localparam int FIFO_BITS     = 7;
  localparam int FIFO_WIDTH    = 8;
  localparam int DEFAULT_LEVEL = 64;

  // One location is kept free so counter == 0 and counter == max never alias.
  localparam logic [FIFO_BITS-1:0] MAX_COUNT = FIFO_BITS'(FIFO_DEPTH - 1);

endpackage

// File: rtl/uart_sync_fifo_128x8_ram.sv
// Simple dual-port RAM, 128x8: synchronous write, read through a registered address.
module fifo_ram_128x8
  import uart_sync_fifo_128x8_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [FIFO_BITS-1:0]  wr_addr,
  input  logic [FIFO_WIDTH-1:0] wr_data,
  input  logic [FIFO_BITS-1:0]  rd_addr,
  output logic [FIFO_WIDTH-1:0] rd_data
);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FIFO_BITS-1:0]  rd_addr_q;

  // NOTE: the storage array has no reset so it maps onto a block RAM; only the
  // address register is cleared.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) rd_addr_q <= '0;
    else       rd_addr_q <= rd_addr;
  end

  assign rd_data = mem[rd_addr_q];

endmodule

// File: rtl/uart_sync_fifo_128x8.sv
// Single-clock 127-byte ring-buffer FIFO with full/empty/threshold flags,
// used as the TX/RX buffer of the APB UART.
module uart_sync_fifo_128x8
  import uart_sync_fifo_128x8_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  write_n,
  input  logic                  read_n,
  input  logic [FIFO_BITS-1:0]  level,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  half
);

  logic [FIFO_BITS-1:0]  rd_pointer;
  logic [FIFO_BITS-1:0]  wr_pointer;
  logic [FIFO_BITS-1:0]  counter;
  logic                  rd_hist_n;
  logic                  rd_accept;
  logic                  wr_accept;
  logic [FIFO_WIDTH-1:0] ram_data;

  assign full  = (counter == MAX_COUNT);
  assign empty = (counter == '0);
  assign half  = (counter >= level);

  // A read on an empty FIFO is dropped even with a write pending; a write on a
  // full FIFO goes through only when a read frees a slot on the same edge.
  assign rd_accept = !read_n && !empty;
  assign wr_accept = !write_n && (!full || rd_accept);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_pointer <= '0;
      wr_pointer <= '0;
      counter    <= '0;
      rd_hist_n  <= 1'b1;
    end else begin
      rd_hist_n <= !rd_accept;
      if (rd_accept) rd_pointer <= rd_pointer + 1'b1;
      if (wr_accept) wr_pointer <= wr_pointer + 1'b1;
      unique case ({wr_accept, rd_accept})
        2'b10:   counter <= counter + 1'b1;
        2'b01:   counter <= counter - 1'b1;
        default: counter <= counter;
      endcase
    end
  end

  // The RAM address register lags rd_pointer by one edge, so the byte
  // selected by a read lands here on the edge after that read.
  always_ff @(posedge clock) begin
    if (reset)           data_out <= '0;
    else if (!rd_hist_n) data_out <= ram_data;
  end

  fifo_ram_128x8 u_ram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_accept),
    .wr_addr (wr_pointer),
    .wr_data (data_in),
    .rd_addr (rd_pointer),
    .rd_data (ram_data)
  );

endmodule

// File: tb/tb_uart_sync_fifo_128x8.sv
// Directed plus randomized bench for uart_sync_fifo_128x8 against a queue model.
module tb_uart_sync_fifo_128x8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = '0;
  logic       write_n = 1'b1;
  logic       read_n = 1'b1;
  logic [6:0] level = 7'd64;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       half;

  int passed = 0;
  int total  = 0;

  logic [7:0] q[$];
  logic [7:0] exp_dout = '0;
  bit         pend_v   = 1'b0;
  logic [7:0] pend_d   = '0;

  always #5 clock = ~clock;

  uart_sync_fifo_128x8 dut (
    .clock    (clock),
    .reset    (reset),
    .data_in  (data_in),
    .write_n  (write_n),
    .read_n   (read_n),
    .level    (level),
    .data_out (data_out),
    .full     (full),
    .empty    (empty),
    .half     (half)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed 0x%02h expected 0x%02h at %0t", tag, obs, expv, $time);
  endtask

  task automatic check_all();
    check("empty", {7'd0, empty}, {7'd0, q.size() == 0});
    check("full", {7'd0, full}, {7'd0, q.size() == 127});
    check("half", {7'd0, half}, {7'd0, q.size() >= int'(level)});
    check("data_out", data_out, exp_dout);
  endtask

  // One clock: drive strobes, let the edge happen, advance the model, compare.
  task automatic cycle(input logic w_n, input logic r_n, input logic [7:0] d,
                       input logic rst = 1'b0);
    bit rd, wr;
    write_n = w_n;
    read_n  = r_n;
    data_in = d;
    reset   = rst;
    @(posedge clock);
    if (rst) begin
      q.delete();
      exp_dout = '0;
      pend_v   = 1'b0;
    end else begin
      rd = !r_n && (q.size() != 0);
      wr = !w_n && ((q.size() != 127) || rd);
      if (pend_v) exp_dout = pend_d;
      pend_v = rd;
      if (rd) begin
        pend_d = q[0];
        void'(q.pop_front());
      end
      if (wr) q.push_back(d);
    end
    #1;
    write_n = 1'b1;
    read_n  = 1'b1;
    reset   = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 8'h00);
  endtask

  task automatic drain();
    while (q.size() > 0) cycle(1'b1, 1'b0, 8'h00);
    idle(2);
  endtask

  initial begin
    // Reset then idle
    level = 7'd64;
    cycle(1'b1, 1'b1, 8'h00, 1'b1);
    cycle(1'b1, 1'b1, 8'h00, 1'b1);
    idle(1);
    check("reset_empty", {7'd0, empty}, 8'h01);
    check("reset_full", {7'd0, full}, 8'h00);
    check("reset_half", {7'd0, half}, 8'h00);
    check("reset_dout", data_out, 8'h00);

    // Three bytes through
    cycle(1'b0, 1'b1, 8'h11);
    cycle(1'b0, 1'b1, 8'h22);
    cycle(1'b0, 1'b1, 8'h33);
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    check("seq_first", data_out, 8'h11);
    cycle(1'b1, 1'b0, 8'h00);
    check("seq_second", data_out, 8'h22);
    idle(1);
    check("seq_third", data_out, 8'h33);
    check("seq_empty", {7'd0, empty}, 8'h01);

    // Fill to capacity, overflow write, then drain in order
    for (int i = 0; i < 127; i++) begin
      cycle(1'b0, 1'b1, 8'(i));
      if (i == 62) check("half_before_64", {7'd0, half}, 8'h00);
      if (i == 63) check("half_at_64", {7'd0, half}, 8'h01);
    end
    check("fill_full", {7'd0, full}, 8'h01);
    cycle(1'b0, 1'b1, 8'hFF);
    check("overflow_full", {7'd0, full}, 8'h01);
    drain();
    check("drain_last", data_out, 8'h7E);
    check("drain_empty", {7'd0, empty}, 8'h01);

    // Pointer wrap with one resident entry; level 1/2 pins the counter at 1
    level = 7'd1;
    cycle(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 300; i++) cycle(1'b0, 1'b0, 8'($urandom));
    level = 7'd2;
    idle(1);
    check("wrap_half_lvl2", {7'd0, half}, 8'h00);
    drain();

    // Simultaneous strobes on empty: write only, data_out held
    level = 7'd1;
    cycle(1'b0, 1'b0, 8'hC3);
    idle(2);
    check("both_empty_half", {7'd0, half}, 8'h01);
    check("both_empty_dout", data_out, exp_dout);

    // Simultaneous strobes on full: both accepted, oldest byte returned
    level = 7'd127;
    while (q.size() < 127) cycle(1'b0, 1'b1, 8'($urandom));
    cycle(1'b0, 1'b0, 8'h3C);
    idle(1);
    check("both_full_dout", data_out, 8'hC3);
    check("both_full_full", {7'd0, full}, 8'h01);
    drain();

    // Reads on empty are ignored
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h77);
    cycle(1'b1, 1'b0, 8'h00);
    idle(2);
    check("after_empty_reads", data_out, 8'h77);

    // Reset with contents stored
    level = 7'd64;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'(8'h80 + i));
    cycle(1'b1, 1'b1, 8'h00, 1'b1);
    check("rst_mid_empty", {7'd0, empty}, 8'h01);
    check("rst_mid_dout", data_out, 8'h00);
    cycle(1'b0, 1'b1, 8'h5A);
    cycle(1'b1, 1'b0, 8'h00);
    idle(2);
    check("post_rst_byte", data_out, 8'h5A);

    // Randomized traffic, including occasional resets and threshold changes
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) level = 7'($urandom);
      cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
            8'($urandom), 1'($urandom_range(0, 499) == 0));
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
